// File: rtl/iorq_rd_fsm.sv
// Z8S180 external I/O read responder: one rd_tick per read cycle, peripheral data held on dout behind dout_oe.
// Optional WAIT/ack handshake with timeout is compiled in by defining IORQ_RD_WAIT_EN.
module iorq_rd_fsm #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             phi,
    input  logic             reset,
    input  logic             iorq,
    input  logic             rd,
    output logic             rd_tick,
    input  logic             rd_ack,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] dout,
    output logic             dout_oe,
    output logic             wait_out,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             q, q_prev_q, start;
    logic             rd_tick_q;
    logic [WIDTH-1:0] dout_q, dout_d;

    assign q     = iorq & rd;
    assign start = q & ~q_prev_q;

`ifdef IORQ_RD_WAIT_EN
    localparam logic [7:0] TMO_V = 8'(TIMEOUT);

    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic       wait_q, timeout_q, timeout_d;

    assign cnt_inc = cnt_q + 8'd1;
`else
    logic unused_cfg;
    assign unused_cfg = rd_ack ^ (TIMEOUT == 0);
`endif

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
`ifdef IORQ_RD_WAIT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_d = REQ;
            end
            REQ: begin
                if (!q) begin
                    state_d = IDLE;
`ifdef IORQ_RD_WAIT_EN
                end else if (rd_ack) begin
                    state_d = HOLD;
                    dout_d  = rd_data;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 8'd0;
                end
`else
                end else begin
                    state_d = HOLD;
                    dout_d  = rd_data;
                end
`endif
            end
            WAIT: begin
`ifdef IORQ_RD_WAIT_EN
                // Ack beats a timeout landing on the same edge.
                if (!q) begin
                    state_d = IDLE;
                end else if (rd_ack) begin
                    state_d = HOLD;
                    dout_d  = rd_data;
                end else if (cnt_inc == TMO_V) begin
                    state_d   = HOLD;
                    dout_d    = '1;
                    timeout_d = 1'b1;
                    cnt_d     = cnt_inc;
                end else begin
                    cnt_d = cnt_inc;
                end
`else
                state_d = IDLE;
`endif
            end
            HOLD: begin
                if (!q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // q_prev resets high so a read already in flight at reset release is not taken.
    always_ff @(posedge phi) begin
        if (reset) begin
            state_q   <= IDLE;
            q_prev_q  <= 1'b1;
            rd_tick_q <= 1'b0;
            dout_q    <= '0;
`ifdef IORQ_RD_WAIT_EN
            cnt_q     <= 8'd0;
            wait_q    <= 1'b0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            q_prev_q  <= q;
            rd_tick_q <= (state_d == REQ);
            dout_q    <= dout_d;
`ifdef IORQ_RD_WAIT_EN
            cnt_q     <= cnt_d;
            wait_q    <= (state_d == REQ) || (state_d == WAIT);
            timeout_q <= timeout_d;
`endif
        end
    end

    assign rd_tick = rd_tick_q;
    assign dout    = dout_q;
    assign dout_oe = (state_q != IDLE) & iorq & rd;

`ifdef IORQ_RD_WAIT_EN
    assign wait_out = wait_q;
    assign timeout  = timeout_q;
`else
    assign wait_out = 1'b0;
    assign timeout  = 1'b0;
`endif

endmodule

// File: doc/iorq_rd_fsm.md
# iorq_rd_fsm

Responder for Z8S180 external I/O read cycles; the read-side counterpart of the I/O write detector. Samples the CPU's IORQ and RD strobes on `phi` and issues a single `rd_tick` request per read cycle to the addressed peripheral. It captures the peripheral's data into a holding register and drives it onto the CPU data bus through an output enable. An optional ready/ack handshake stretches the CPU cycle with WAIT and bounds it with a timeout.

## Interface
- `WIDTH`, default 8: data bus width.
- `TIMEOUT`, default 15: maximum phi cycles spent in WAIT before forced completion. Range 1..255.

- `phi` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `iorq` in 1: CPU IORQ, positive logic; asynchronous to `phi` edges.
- `rd` in 1: CPU RD, positive logic.
- `rd_tick` out 1: registered one-cycle request to the peripheral.
- `rd_ack` in 1: peripheral data-valid. Used only with `IORQ_RD_WAIT_EN`.
- `rd_data` in WIDTH: peripheral read data.
- `dout` out WIDTH: held read data for the CPU bus.
- `dout_oe` out 1: data bus drive enable.
- `wait_out` out 1: WAIT request to the CPU, positive logic. Tied 0 without `IORQ_RD_WAIT_EN`.
- `timeout` out 1: one-cycle pulse on forced completion. Tied 0 without `IORQ_RD_WAIT_EN`.

## Operation
- Qualifier `q = iorq & rd`, sampled each rising `phi`; `q_prev` holds the previous sample.
- Start condition: `q & ~q_prev`. Exactly one start per read cycle, whatever the cycle length.
- States:
  - IDLE: on start, go to REQ.
  - REQ: `rd_tick`=1 for exactly this cycle. Next edge goes to HOLD without wait support, or to WAIT with it.
  - WAIT: wait for `rd_ack`, counting cycles, then go to HOLD.
  - HOLD: stay while `q`=1. Go to IDLE on the first edge with `q`=0.
- Data capture without `IORQ_RD_WAIT_EN`: `dout <= rd_data` on the REQ→HOLD edge.
- In any non-IDLE state, `q`=0 sampled aborts to IDLE. On abort, `dout` keeps its prior value and no `timeout` pulse is issued.
- `dout_oe = (state != IDLE) & iorq & rd`. This is combinational, so the bus is released immediately when the strobes drop, with no wait for an edge.
- `dout` holds its value between cycles. It changes only on capture, on forced completion, or on reset.

## Timing
- Reset values: state=IDLE; `rd_tick`=0; `dout`=0; `wait_out`=0; `timeout`=0; counter=0.
- `q_prev` resets to 1. A read already in progress when reset releases does not trigger; the strobes must drop first.
- Start sampled at edge k: `rd_tick` is high from k to k+1.
- Without wait: `dout` is valid from edge k+1.
- With wait: `wait_out` rises at edge k, together with `rd_tick`.
  - `rd_ack` sampled high at edge k+1 or later: capture at that edge and drop `wait_out` there.
  - Minimum stretch is 1 phi cycle.
- WAIT counter:
  - Clears on entry to WAIT.
  - Increments each edge in WAIT without ack.
  - At count == TIMEOUT: `dout <= {WIDTH{1'b1}}`, `wait_out`=0, `timeout` pulses for one cycle, state goes to HOLD.
- Ack and timeout on the same edge: ack wins, `rd_data` is captured, and there is no `timeout` pulse.
- `rd_ack` outside WAIT or REQ is ignored.
- A strobe edge landing exactly on a `phi` edge may be seen one cycle late. Latency is 1 or 2 cycles from the strobe, and this is acceptable.
- Back-to-back reads: after IDLE, a new start needs `q` sampled 0 at least once.

## Configuration
- `IORQ_RD_WAIT_EN` defined:
  - WAIT state, counter, `rd_ack` handshake, `wait_out` and `timeout` are all active.
  - Zero-wait peripherals tie `rd_ack`=1, which gives the minimum 1-cycle stretch.
- `IORQ_RD_WAIT_EN` undefined:
  - No WAIT state and no counter.
  - `wait_out` and `timeout` are constant 0 and `rd_ack` is unused.
  - Peripheral `rd_data` must be valid in the cycle after `rd_tick`.

## Test plan
- Reset and plain read:
  - Stimulus: reset, then `iorq`/`rd` high 1ns after phi falling, with `rd_data`=8'hA5.
  - Response: one `rd_tick` pulse, `dout`=8'hA5 at the next edge, and `dout_oe` high until `iorq` drops at T1 rising. Then `dout_oe` goes 0 the same instant and `dout` stays 8'hA5.
- Long cycle:
  - Stimulus: strobes held 5 cycles, as with extra TW.
  - Response: exactly one `rd_tick`; 4 consecutive reads give 4 ticks.
- Wait handshake (macro on):
  - Stimulus: `rd_ack` asserted 3 cycles after `rd_tick`, with `rd_data`=8'h3C.
  - Response: `wait_out` high for 3 cycles, then `dout`=8'h3C and `wait_out` low.
- Timeout (macro on, TIMEOUT=4):
  - Stimulus: `rd_ack` never asserted.
  - Response: `dout`=8'hFF, a single `timeout` pulse, and `wait_out` low after 4 WAIT cycles. Also repeat with ack arriving on the timeout edge and check ack wins.
- Abort:
  - Stimulus: `rd` drops during WAIT.
  - Response: IDLE next edge, `wait_out` 0, `dout_oe` 0 immediately, `dout` unchanged, no `timeout`.
- Reset mid-cycle:
  - Stimulus: reset during HOLD with strobes still high.
  - Response: outputs return to reset values, and no `rd_tick` until the strobes drop and reassert.
